debug_unit: RTL and testbench

- Host-side controller for the pipeline's load/run/debug interface.
- Receives a byte stream from a UART receiver and assembles 32-bit instructions, writing them into the pipeline's instruction memory.
- Drives the pipeline enable in continuous or single-step mode.
- After a run or step ends, snapshots the pipeline PC and debug-memory word and streams them back through a UART transmitter.

---
 rtl/debug_unit.sv | 139 +++++++++++++
 tb/tb_debug_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// debug_unit: host-side load/run/step controller for the pipeline.
// Assembles instructions from received UART bytes and writes them to instruction
// memory. Runs the pipeline continuously or for a single step. Once the run or
// step ends, it reports the PC and debug-memory word back over the UART.
module debug_unit #(
    parameter int unsigned         INST_SZ    = 32,
    parameter int unsigned         PC_SZ      = 32,
    parameter int unsigned         BYTE_SZ    = 8,
    parameter logic [INST_SZ-1:0]  HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [BYTE_SZ-1:0]  CMD_LOAD   = 8'h4C,
    parameter logic [BYTE_SZ-1:0]  CMD_RUN    = 8'h43,
    parameter logic [BYTE_SZ-1:0]  CMD_STEP   = 8'h53
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [BYTE_SZ-1:0] o_tx_data,
    input  logic               i_halt,
    input  logic [PC_SZ-1:0]   i_pc,
    input  logic [INST_SZ-1:0] i_data,
    output logic               o_write,
    output logic               o_enable,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_busy
);

    localparam int unsigned SNAP_W     = PC_SZ + INST_SZ;
    localparam int unsigned INST_BYTES = INST_SZ / BYTE_SZ;
    localparam int unsigned SNAP_BYTES = SNAP_W / BYTE_SZ;

    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, RUN, STEP, SNAP, REPORT, TX_WAIT
    } state_t;

    state_t              state_q,  state_d;
    logic [INST_SZ-1:0]  word_q,   word_d;
    logic [1:0]          ld_cnt_q, ld_cnt_d;
    logic [INST_SZ-1:0]  instr_q,  instr_d;
    logic [SNAP_W-1:0]   snap_q,   snap_d;
    logic [2:0]          rpt_cnt_q, rpt_cnt_d;

    // State and datapath registers; reset aborts any load or report in progress.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            ld_cnt_q  <= '0;
            instr_q   <= '0;
            snap_q    <= '0;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            ld_cnt_q  <= ld_cnt_d;
            instr_q   <= instr_d;
            snap_q    <= snap_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    // Next-state and datapath updates; all registers hold unless a state moves them.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        ld_cnt_d  = ld_cnt_q;
        instr_d   = instr_q;
        snap_d    = snap_q;
        rpt_cnt_d = rpt_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d  = LOAD;
                        ld_cnt_d = '0;
                    end else if (i_rx_data == CMD_RUN) begin
                        state_d = RUN;
                    end else if (i_rx_data == CMD_STEP) begin
                        state_d = STEP;
                    end
                end
            end
            LOAD: begin
                if (i_rx_done) begin
                    // Bytes arrive MSB first; the oldest byte shifts out of the top.
                    word_d = (word_q << BYTE_SZ) | INST_SZ'(i_rx_data);
                    if (ld_cnt_q == 2'(INST_BYTES - 1)) begin
                        // Capture the word here so it appears alongside the write strobe.
                        instr_d  = word_d;
                        ld_cnt_d = '0;
                        state_d  = WRITE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                state_d = (instr_q == HALT_INSTR) ? IDLE : LOAD;
            end
            RUN: begin
                if (i_halt) state_d = SNAP;
            end
            STEP: begin
                state_d = SNAP;
            end
            SNAP: begin
                snap_d    = {i_pc, i_data};
                rpt_cnt_d = '0;
                state_d   = REPORT;
            end
            REPORT: begin
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    // The next byte to send always sits at the top of the snapshot.
                    snap_d    = snap_q << BYTE_SZ;
                    rpt_cnt_d = rpt_cnt_q + 3'd1;
                    state_d   = (rpt_cnt_q == 3'(SNAP_BYTES - 1)) ? IDLE : REPORT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; the enable follows halt combinationally.
    always_comb begin
        o_write       = (state_q == WRITE);
        o_instruction = instr_q;
        o_enable      = ((state_q == RUN) || (state_q == STEP)) && !i_halt;
        o_tx_start    = (state_q == REPORT);
        o_tx_data     = snap_q[SNAP_W-1 -: BYTE_SZ];
        o_busy        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: scoreboard bench for debug_unit. The stimulus pushes expected
// writes and TX bytes into queues, and a negedge monitor pops and compares them.
module tb_debug_unit;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_done = 1'b0;
    logic        i_tx_done = 1'b0;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_halt = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_data = '0;
    logic        o_write;
    logic        o_enable;
    logic [31:0] o_instruction;
    logic        o_busy;

    debug_unit dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_halt(i_halt), .i_pc(i_pc), .i_data(i_data),
        .o_write(o_write), .o_enable(o_enable),
        .o_instruction(o_instruction), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    int en_cnt = 0;
    int unstable = 0;
    int extra_start = 0;
    int tx_delay = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic push_report(input logic [31:0] pc, input logic [31:0] dat);
        logic [63:0] s;
        s = {pc, dat};
        for (int i = 7; i >= 0; i--) exp_tx.push_back(s[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy && n < 3000) begin
            tick();
            n++;
        end
        check(name, {31'd0, o_busy}, 32'd0);
    endtask

    // Monitor: compare every write strobe and TX start against the scoreboard.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_reset) begin
                if (o_write) begin
                    if (exp_wr.size() == 0) check("unexpected_write", o_instruction, 32'hxxxx_xxxx);
                    else check("write_word", o_instruction, exp_wr.pop_front());
                end
                if (o_tx_start) begin
                    if (exp_tx.size() == 0) check("unexpected_tx", {24'd0, o_tx_data}, 32'hxxxx_xxxx);
                    else check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_tx.pop_front()});
                end
                if (o_enable) en_cnt++;
            end
        end
    end

    // TX responder: acknowledge each byte after tx_delay cycles, watching that the byte holds.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge i_clk);
            if (o_tx_start && !i_reset) begin
                b = o_tx_data;
                for (int i = 0; i < tx_delay; i++) begin
                    @(negedge i_clk);
                    if (o_tx_data !== b) unstable++;
                    if (o_tx_start) extra_start++;
                end
                @(posedge i_clk);
                #1 i_tx_done = 1'b1;
                @(posedge i_clk);
                #1 i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        repeat (3) tick();
        // Reset state
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_write", {31'd0, o_write}, 32'd0);
        check("rst_enable", {31'd0, o_enable}, 32'd0);
        check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_instr", o_instruction, 32'd0);
        i_reset = 1'b0;

        // Aborted load: two bytes, then reset
        send_byte(8'h4C);
        send_byte(8'h12);
        send_byte(8'h34);
        check("load_busy", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_instr", o_instruction, 32'd0);

        // Full load: one instruction, then the halt word
        exp_wr.push_back(32'h2001_0005);
        exp_wr.push_back(32'hFFFF_FFFF);
        send_byte(8'h4C);
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        repeat (2) tick();
        check("load_done_busy", {31'd0, o_busy}, 32'd0);
        check("instr_hold", o_instruction, 32'hFFFF_FFFF);
        check("wr_queue_empty", exp_wr.size(), 32'd0);

        // Unknown byte in IDLE
        send_byte(8'h41);
        check("unknown_busy", {31'd0, o_busy}, 32'd0);

        // Continuous run, halt after 10 enabled cycles
        en_cnt = 0;
        push_report(32'h0000_0024, 32'h0000_00AB);
        send_byte(8'h43);
        repeat (10) tick();
        i_pc = 32'h0000_0024;
        i_data = 32'h0000_00AB;
        i_halt = 1'b1;
        // Bytes received while the report is in flight must be ignored
        repeat (6) tick();
        send_byte(8'h4C);
        send_byte(8'h53);
        wait_idle("run_idle");
        check("run_enable_cycles", en_cnt, 32'd10);
        i_halt = 1'b0;

        // Single step with slow transmitter
        en_cnt = 0;
        tx_delay = 50;
        unstable = 0;
        extra_start = 0;
        i_pc = 32'h0000_0010;
        i_data = 32'hDEAD_BEEF;
        push_report(32'h0000_0010, 32'hDEAD_BEEF);
        send_byte(8'h53);
        wait_idle("step_idle");
        check("step_enable_cycles", en_cnt, 32'd1);
        check("tx_data_stable", unstable, 32'd0);
        check("no_extra_start", extra_start, 32'd0);
        tx_delay = 2;

        // Run with halt already asserted
        en_cnt = 0;
        i_halt = 1'b1;
        i_pc = 32'h0000_0030;
        i_data = 32'h1234_5678;
        push_report(32'h0000_0030, 32'h1234_5678);
        send_byte(8'h43);
        wait_idle("halted_run_idle");
        check("halted_enable_cycles", en_cnt, 32'd0);
        i_halt = 1'b0;

        repeat (3) tick();
        check("tx_queue_empty", exp_tx.size(), 32'd0);
        check("wr_queue_final", exp_wr.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog: the run must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
